sb_arb: RTL and testbench

Parametrised system-bus arbiter. It connects `NUM_M` masters (execute stage, fetch/PC, debug/DMA) to one synchronous single-port memory slave. Each master issues a request/acknowledge transaction, and the block arbitrates, checks alignment, generates byte enables and sign/zero-extends read data. Only one transaction is in flight at a time, using a three-state FSM.

---
 rtl/sb_arb.sv | 159 +++++++++++++++
 tb/tb_sb_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_arb.sv
// System-bus arbiter: NUM_M masters share one synchronous single-port memory slave, one transaction in flight.
// Define SB_RR_EN for round-robin arbitration; the default build uses fixed priority (index 0 highest).
//
// state   | meaning
// IDLE    | no transaction; arbitrate and latch the winner's request
// ADDR    | present address/byte enables/write data to the slave (suppressed on alignment error)
// DATA    | slave read data valid; ack the winner with formatted data or error
module sb_arb #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_M-1:0]        m_req,
   input  logic [NUM_M-1:0]        m_we,
   input  logic [NUM_M-1:0]        m_un_sign,
   input  logic [2*NUM_M-1:0]      m_size,
   input  logic [ADDR_W*NUM_M-1:0] m_addr,
   input  logic [32*NUM_M-1:0]     m_wdata,
   output logic [NUM_M-1:0]        m_ack_o,
   output logic                    m_err_o,
   output logic [31:0]             m_rdata_o,
   output logic                    s_req_o,
   output logic                    s_we_o,
   output logic [3:0]              s_be_o,
   output logic [ADDR_W-1:0]       s_addr_o,
   output logic [31:0]             s_wdata_o,
   input  logic [31:0]             s_rdata
);
   localparam int IDX_W = $clog2(NUM_M);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  grant_idx, idx_q;
   logic              grant_vld;
   logic              we_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              err;
   logic [31:0]       rd_shift;
`ifdef SB_RR_EN
   logic [IDX_W-1:0]  rr_ptr;
`endif

   // Winner search; in round-robin the scan starts just past the last grant.
   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
`ifdef SB_RR_EN
      for (int k = 1; k <= NUM_M; k++) begin
         if (!grant_vld && m_req[(int'(rr_ptr) + k) % NUM_M]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_M);
         end
      end
`else
      for (int i = NUM_M - 1; i >= 0; i--) begin
         if (m_req[i]) begin
            grant_vld = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx_q   <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef SB_RR_EN
         rr_ptr  <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && grant_vld) begin
            idx_q   <= grant_idx;
            we_q    <= m_we[grant_idx];
            uns_q   <= m_un_sign[grant_idx];
            size_q  <= m_size[2*int'(grant_idx) +: 2];
            addr_q  <= m_addr[ADDR_W*int'(grant_idx) +: ADDR_W];
            wdata_q <= m_wdata[32*int'(grant_idx) +: 32];
`ifdef SB_RR_EN
            rr_ptr  <= grant_idx;
`endif
         end
      end
   end

   always_comb begin
      case (size_q)
         2'b00:   err = 1'b0;
         2'b01:   err = addr_q[0];
         2'b10:   err = |addr_q[1:0];
         default: err = 1'b1;
      endcase
   end

   assign rd_shift = s_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      state_nxt = state;
      m_ack_o   = '0;
      m_err_o   = 1'b0;
      m_rdata_o = '0;
      s_req_o   = 1'b0;
      s_we_o    = 1'b0;
      s_be_o    = 4'b0000;
      s_addr_o  = '0;
      s_wdata_o = '0;
      case (state)
         ST_IDLE: begin
            if (grant_vld) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            state_nxt = ST_DATA;
            if (!err) begin
               s_req_o  = 1'b1;
               s_we_o   = we_q;
               s_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
               case (size_q)
                  2'b00: begin
                     s_be_o    = 4'b0001 << addr_q[1:0];
                     s_wdata_o = {4{wdata_q[7:0]}};
                  end
                  2'b01: begin
                     s_be_o    = 4'b0011 << {addr_q[1], 1'b0};
                     s_wdata_o = {2{wdata_q[15:0]}};
                  end
                  default: begin
                     s_be_o    = 4'b1111;
                     s_wdata_o = wdata_q;
                  end
               endcase
            end
         end
         ST_DATA: begin
            state_nxt      = ST_IDLE;
            m_ack_o[idx_q] = 1'b1;
            if (err) begin
               m_err_o = 1'b1;
            end else if (!we_q) begin
               case (size_q)
                  2'b00:   m_rdata_o = {{24{rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
                  2'b01:   m_rdata_o = {{16{rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
                  default: m_rdata_o = rd_shift;
               endcase
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_sb_arb.sv
// Self-checking bench for sb_arb: cycle-indexed scoreboard model plus directed literal checks.
module tb_sb_arb;
   localparam int NUM_M = 2;
   localparam int AW    = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_M-1:0]  m_req = '0, m_we = '0, m_un_sign = '0;
   logic [2*NUM_M-1:0] m_size = '0;
   logic [AW*NUM_M-1:0] m_addr = '0;
   logic [32*NUM_M-1:0] m_wdata = '0;
   logic [NUM_M-1:0]  m_ack_o;
   logic              m_err_o;
   logic [31:0]       m_rdata_o;
   logic              s_req_o, s_we_o;
   logic [3:0]        s_be_o;
   logic [AW-1:0]     s_addr_o;
   logic [31:0]       s_wdata_o;
   logic [31:0]       s_rdata = '0;

   int tests = 0;
   int fails = 0;

   sb_arb #(.NUM_M(NUM_M), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_un_sign(m_un_sign),
      .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          idx;
      bit          we;
      bit          uns;
      int          size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t slv_exp[int];
   txn_t ack_exp[int];
   int   cyc = 0;
   int   free_at = 0;
   int   rr_last = 0;

   function automatic bit is_err(txn_t t);
      return (t.size == 3) || (t.size == 1 && t.addr % 2 != 0) || (t.size == 2 && t.addr % 4 != 0);
   endfunction

   function automatic int pick(logic [NUM_M-1:0] req);
`ifdef SB_RR_EN
      for (int k = 1; k <= NUM_M; k++)
         if (req[(rr_last + k) % NUM_M]) return (rr_last + k) % NUM_M;
`else
      for (int i = 0; i < NUM_M; i++)
         if (req[i]) return i;
`endif
      return 0;
   endfunction

   function automatic logic [31:0] fmt_read(txn_t t, logic [31:0] raw);
      logic [31:0] v;
      v = raw >> (8 * (t.addr % 4));
      if (t.size == 0) begin
         v = v & 32'hFF;
         if (!t.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (t.size == 1) begin
         v = v & 32'hFFFF;
         if (!t.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   always @(posedge clk) begin
      txn_t t;
      int   w;
      cyc++;
      if (rst) begin
         for (int k = cyc; k < cyc + 4; k++) begin
            slv_exp.delete(k);
            ack_exp.delete(k);
         end
         free_at = cyc + 1;
         rr_last = 0;
      end else if (cyc >= free_at && m_req != '0) begin
         w       = pick(m_req);
         t.idx   = w;
         t.we    = m_we[w];
         t.uns   = m_un_sign[w];
         t.size  = int'(m_size[2*w +: 2]);
         t.addr  = m_addr[AW*w +: AW];
         t.wdata = m_wdata[32*w +: 32];
         slv_exp[cyc]     = t;
         ack_exp[cyc + 1] = t;
         free_at = cyc + 3;
         rr_last = w;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      txn_t        t;
      logic [5:0]  e_ctl;
      logic [31:0] e_addr, e_wd, e_rd;
      logic [NUM_M-1:0] e_ack;
      logic        e_err;
      if (cmp_en) begin
         e_ctl = '0; e_addr = '0; e_wd = '0;
         e_ack = '0; e_err = 1'b0; e_rd = '0;
         if (slv_exp.exists(cyc)) begin
            t = slv_exp[cyc];
            if (!is_err(t)) begin
               e_addr = t.addr - (t.addr % 4);
               if (t.size == 0) begin
                  e_ctl = {1'b1, t.we, 4'(1 << (t.addr % 4))};
                  e_wd  = (t.wdata & 32'hFF) * 32'h0101_0101;
               end else if (t.size == 1) begin
                  e_ctl = {1'b1, t.we, 4'(3 << (t.addr % 4))};
                  e_wd  = (t.wdata & 32'hFFFF) * 32'h0001_0001;
               end else begin
                  e_ctl = {1'b1, t.we, 4'hF};
                  e_wd  = t.wdata;
               end
            end
         end
         if (ack_exp.exists(cyc)) begin
            t = ack_exp[cyc];
            e_ack = NUM_M'(1 << t.idx);
            e_err = is_err(t);
            e_rd  = (e_err || t.we) ? 32'h0 : fmt_read(t, s_rdata);
         end
         chk("slave_ctl", 32'({s_req_o, s_we_o, s_be_o}), 32'(e_ctl));
         chk("slave_addr", s_addr_o, e_addr);
         chk("slave_wdata", s_wdata_o, e_wd);
         chk("master_ack_err", 32'({m_ack_o, m_err_o}), 32'({e_ack, e_err}));
         chk("master_rdata", m_rdata_o, e_rd);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic txn(input int idx, input bit we, input bit uns, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                      output int lat, output logic [31:0] rd, output logic er, output bit saw,
                      output logic [31:0] sa, output logic [3:0] be, output logic [31:0] swd,
                      output logic swe);
      bit got;
      got = 0; saw = 0; lat = 0; rd = '0; er = 1'b0; sa = '0; be = '0; swd = '0; swe = 1'b0;
      s_rdata                = rdv;
      m_we[idx]              = we;
      m_un_sign[idx]         = uns;
      m_size[2*idx +: 2]     = sz;
      m_addr[AW*idx +: AW]   = addr;
      m_wdata[32*idx +: 32]  = wd;
      m_req[idx]             = 1'b1;
      for (int n = 1; n <= 10 && !got; n++) begin
         @(negedge clk);
         if (s_req_o) begin
            saw = 1; sa = s_addr_o; be = s_be_o; swd = s_wdata_o; swe = s_we_o;
         end
         if (m_ack_o[idx]) begin
            got = 1; lat = n; rd = m_rdata_o; er = m_err_o;
         end
      end
      m_req[idx] = 1'b0;
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL ack_timeout: master %0d got no ack within 10 cycles", idx);
      end
   endtask

   initial begin
      int          lat, nack;
      logic [31:0] rd, sa, swd;
      logic [3:0]  be;
      logic        er, swe;
      bit          saw, seen_ack;
      int          grants[4];
      int          exp_g[4];

      @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // aligned word read
      txn(0, 0, 0, 2'b10, 32'h0000_0010, 32'h0, 32'h8123_4567, lat, rd, er, saw, sa, be, swd, swe);
      chk("word_latency", 32'(lat), 32'd2);
      chk("word_rdata", rd, 32'h8123_4567);
      chk("word_be", 32'(be), 32'hF);
      chk("word_err", 32'(er), 32'd0);
      @(negedge clk);

      // byte/half reads
      txn(0, 0, 0, 2'b00, 32'h3, 32'h0, 32'h80F0_7F01, lat, rd, er, saw, sa, be, swd, swe);
      chk("byte_signed", rd, 32'hFFFF_FF80);
      @(negedge clk);
      txn(0, 0, 1, 2'b00, 32'h3, 32'h0, 32'h80F0_7F01, lat, rd, er, saw, sa, be, swd, swe);
      chk("byte_unsigned", rd, 32'h0000_0080);
      @(negedge clk);
      txn(0, 0, 0, 2'b01, 32'h2, 32'h0, 32'h80F0_7F01, lat, rd, er, saw, sa, be, swd, swe);
      chk("half_signed", rd, 32'hFFFF_80F0);
      @(negedge clk);

      // misaligned half then word
      txn(0, 0, 0, 2'b01, 32'h5, 32'h0, 32'hDEAD_BEEF, lat, rd, er, saw, sa, be, swd, swe);
      chk("mis_half_sreq", 32'(saw), 32'd0);
      chk("mis_half_err", 32'(er), 32'd1);
      chk("mis_half_rdata", rd, 32'h0);
      @(negedge clk);
      txn(0, 0, 0, 2'b10, 32'h6, 32'h0, 32'hDEAD_BEEF, lat, rd, er, saw, sa, be, swd, swe);
      chk("mis_word_sreq", 32'(saw), 32'd0);
      chk("mis_word_err", 32'(er), 32'd1);
      @(negedge clk);

      // reserved size is rejected too
      txn(0, 1, 0, 2'b11, 32'h8, 32'h1234, 32'h0, lat, rd, er, saw, sa, be, swd, swe);
      chk("rsv_size_err", 32'({saw, er}), 32'b01);
      @(negedge clk);

      // half write to upper lanes
      txn(1, 1, 0, 2'b01, 32'h42, 32'h0000_BEEF, 32'h0, lat, rd, er, saw, sa, be, swd, swe);
      chk("half_wr_be", 32'(be), 32'hC);
      chk("half_wr_wdata", swd, 32'hBEEF_BEEF);
      @(negedge clk);

      // byte write by M1 (last grant before contention goes to M1)
      txn(1, 1, 0, 2'b00, 32'h101, 32'h0000_00AB, 32'h0, lat, rd, er, saw, sa, be, swd, swe);
      chk("bwr_addr", sa, 32'h100);
      chk("bwr_be", 32'(be), 32'h2);
      chk("bwr_wdata", swd, 32'hABAB_ABAB);
      chk("bwr_we", 32'(swe), 32'd1);
      chk("bwr_rdata", rd, 32'h0);
      @(negedge clk);

      // contention: both masters hold requests for four grants
      s_rdata = 32'h1122_3344;
      m_we = '0; m_un_sign = '0; m_size = {2'b10, 2'b10};
      m_addr = {32'h24, 32'h20};
      m_req = 2'b11;
      nack = 0;
      for (int n = 0; n < 40 && nack < 4; n++) begin
         @(negedge clk);
         if (m_ack_o != '0) begin
            grants[nack] = m_ack_o[1] ? 1 : 0;
            nack++;
         end
      end
      m_req = '0;
`ifdef SB_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      chk("cont_count", 32'(nack), 32'd4);
      for (int g = 0; g < 4; g++) chk("cont_grant", 32'(grants[g]), 32'(exp_g[g]));
      @(negedge clk);

      // reset during ADDR of a read
      s_rdata = 32'hCAFE_F00D;
      m_size[1:0] = 2'b10; m_addr[31:0] = 32'h40; m_we[0] = 1'b0;
      m_req[0] = 1'b1;
      @(negedge clk);
      chk("rst_in_addr", 32'(s_req_o), 32'd1);
      rst = 1'b1;
      m_req[0] = 1'b0;
      seen_ack = 0;
      @(negedge clk);
      if (m_ack_o != '0) seen_ack = 1;
      chk("rst_outputs", 32'({m_ack_o, m_err_o, s_req_o, s_we_o, s_be_o}) | m_rdata_o | s_addr_o | s_wdata_o, 32'h0);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (m_ack_o != '0) seen_ack = 1;
      end
      chk("rst_no_ack", 32'(seen_ack), 32'd0);
      txn(0, 0, 1, 2'b01, 32'h42, 32'h0, 32'h8001_7FFF, lat, rd, er, saw, sa, be, swd, swe);
      chk("post_rst_latency", 32'(lat), 32'd2);
      chk("post_rst_rdata", rd, 32'h0000_8001);
      @(negedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
